// File: rtl/exec_unit.sv
// Multi-cycle execute/write-back controller for the 8-bit CPU: fetches operands
// from the register file, runs the ALU or a shift-add multiplier, and writes back once.
module exec_unit #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 5,
  parameter int INSTR_W    = 19,
  parameter int MUL_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  rd,
  output logic [ADDR_W-1:0]  rs,
  input  logic [DATA_W-1:0]  rd_data,
  input  logic [DATA_W-1:0]  rs_data,
  output logic               write,
  output logic [ADDR_W-1:0]  wd,
  output logic [DATA_W-1:0]  wdata,
  output logic               done,
  output logic               illegal,
  output logic               flag_z,
  output logic               flag_c,
  output logic               busy
);

  localparam int CNT_W = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, READ, EXEC, MUL, WB} state_t;

  state_t                state, state_nxt;
  logic [INSTR_W-1:0]    ir;
  logic [DATA_W-1:0]     op_a, op_b, result;
  logic [2*DATA_W-1:0]   prod, mul_next;
  logic [DATA_W:0]       mul_sum, alu;
  logic [CNT_W-1:0]      cnt;
  logic                  cand_z, cand_c, flag_z_q, flag_c_q;
  logic [3:0]            op;

  function automatic logic op_writes(input logic [3:0] o);
    return (o >= 4'd1) && (o <= 4'd10);
  endfunction

  function automatic logic op_sets_flags(input logic [3:0] o);
    return ((o >= 4'd1) && (o <= 4'd7)) || (o == 4'd10) || (o == 4'd11);
  endfunction

  assign op = ir[18:15];
  assign wd = ir[14:10];
  assign rd = ir[9:5];
  assign rs = ir[4:0];

  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = (state == WB);
  assign write       = (state == WB) && op_writes(op);
  assign illegal     = (state == WB) && (op >= 4'd12);
  assign wdata       = result;
  // Flags become visible in the write-back cycle itself, then stay registered.
  assign flag_z = ((state == WB) && op_sets_flags(op)) ? cand_z : flag_z_q;
  assign flag_c = ((state == WB) && op_sets_flags(op)) ? cand_c : flag_c_q;

  always_comb begin
    alu = '0;
    case (op)
      4'd1:         alu = {1'b0, op_a} + {1'b0, op_b};
      4'd2, 4'd11:  alu = {1'b0, op_a} - {1'b0, op_b};
      4'd3:         alu = {1'b0, op_a & op_b};
      4'd4:         alu = {1'b0, op_a | op_b};
      4'd5:         alu = {1'b0, op_a ^ op_b};
      4'd6:         alu = {op_a, 1'b0};
      4'd7:         alu = {op_a[0], 1'b0, op_a[DATA_W-1:1]};
      4'd8:         alu = {1'b0, ir[7:0]};
      4'd9:         alu = {1'b0, op_a};
      default:      alu = '0;
    endcase
  end

  // One shift-add step: conditionally add A into the high half, then shift right.
  assign mul_sum  = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, op_a} : '0);
  assign mul_next = {mul_sum, prod[DATA_W-1:1]};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (instr_valid) state_nxt = READ;
      READ:    state_nxt = (op == 4'd10) ? MUL : EXEC;
      EXEC:    state_nxt = WB;
      MUL:     if (cnt == CNT_LAST) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ir       <= '0;
      op_a     <= '0;
      op_b     <= '0;
      prod     <= '0;
      cnt      <= '0;
      result   <= '0;
      cand_z   <= 1'b0;
      cand_c   <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (instr_valid) ir <= instr;
        READ: begin
          op_a <= rd_data;
          op_b <= rs_data;
          prod <= {{DATA_W{1'b0}}, rs_data};
          cnt  <= '0;
        end
        EXEC: begin
          result <= alu[DATA_W-1:0];
          cand_c <= alu[DATA_W];
          cand_z <= (alu[DATA_W-1:0] == '0);
        end
        MUL: begin
          prod <= mul_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            result <= mul_next[DATA_W-1:0];
            cand_c <= |mul_next[2*DATA_W-1:DATA_W];
            cand_z <= (mul_next[DATA_W-1:0] == '0);
          end
        end
        WB: if (op_sets_flags(op)) begin
          flag_z_q <= cand_z;
          flag_c_q <= cand_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed testbench for exec_unit with a behavioural 32x8 register file.
module tb_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [18:0] instr;
  logic [4:0]  rd, rs, wd;
  logic [7:0]  rd_data, rs_data, wdata;
  logic        write, done, illegal, flag_z, flag_c, busy;

  logic [7:0]  regs [32];
  int          checks = 0;
  int          errors = 0;
  int          nwrites;
  logic [7:0]  exp_wd [3];

  exec_unit dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rd(rd), .rs(rs), .rd_data(rd_data), .rs_data(rs_data),
    .write(write), .wd(wd), .wdata(wdata), .done(done), .illegal(illegal),
    .flag_z(flag_z), .flag_c(flag_c), .busy(busy)
  );

  always #5 clk = ~clk;

  assign rd_data = regs[rd];
  assign rs_data = regs[rs];

  always @(posedge clk) if (write) regs[wd] <= wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [18:0] mk(input logic [3:0] op, input logic [4:0] w,
                                     input logic [4:0] a, input logic [4:0] b);
    return {op, w, a, b};
  endfunction

  // Offers an instruction in the current (idle) cycle, leaving the bench in cycle 1.
  task automatic issue(input logic [18:0] word);
    instr       = word;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 8'h00;
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
    step(); step();
    check("rst_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_ctl", {write, done, illegal}, 0);
    check("rst_flags", {flag_z, flag_c}, 0);
    check("rst_addr", {rd, rs, wd, wdata}, 0);
    rst_n = 1'b1;
    step();

    // ADD r3 = 0x0F + 0xF1 -> 0x00 with carry
    regs[1] = 8'h0F; regs[2] = 8'hF1;
    issue(mk(4'd1, 5'd3, 5'd1, 5'd2));
    check("add_c1_ready", instr_ready, 0);
    check("add_c1_busy", busy, 1);
    check("add_c1_addr", {rd, rs}, {5'd1, 5'd2});
    step();
    check("add_c2_write", write, 0);
    step();
    check("add_c3_ctl", {write, done, illegal}, 3'b110);
    check("add_c3_wd", wd, 3);
    check("add_c3_wdata", wdata, 8'h00);
    check("add_c3_flags", {flag_z, flag_c}, 2'b11);
    step();
    check("add_c4_ready", instr_ready, 1);
    check("add_c4_ctl", {write, done}, 0);
    check("add_c4_flags", {flag_z, flag_c}, 2'b11);
    check("add_reg3", regs[3], 8'h00);

    // LDI r5 = 0xA5, flags held
    issue({4'd8, 5'd5, 10'h0A5});
    step(); step();
    check("ldi_ctl", {write, done}, 2'b11);
    check("ldi_wd", wd, 5);
    check("ldi_wdata", wdata, 8'hA5);
    check("ldi_flags", {flag_z, flag_c}, 2'b11);
    step();

    // Illegal opcode 13
    issue(mk(4'd13, 5'd6, 5'd1, 5'd2));
    step(); step();
    check("ill_ctl", {write, done, illegal}, 3'b011);
    check("ill_flags", {flag_z, flag_c}, 2'b11);
    step();
    check("ill_after", {illegal, done}, 0);

    // SUB r3 = 0x05 - 0x07 -> 0xFE with borrow
    regs[1] = 8'h05; regs[2] = 8'h07;
    issue(mk(4'd2, 5'd3, 5'd1, 5'd2));
    step(); step();
    check("sub_ctl", {write, done}, 2'b11);
    check("sub_wdata", wdata, 8'hFE);
    check("sub_flags", {flag_z, flag_c}, 2'b01);
    step();

    // XOR r7 = r1 ^ r1 -> 0, sets z=1 c=0 so the CMP flag change is observable
    issue(mk(4'd5, 5'd7, 5'd1, 5'd1));
    step(); step();
    check("xor_wdata", wdata, 8'h00);
    check("xor_flags", {flag_z, flag_c}, 2'b10);
    step();

    // CMP 0x05 vs 0x07: flags as SUB, no write
    issue(mk(4'd11, 5'd3, 5'd1, 5'd2));
    step(); step();
    check("cmp_ctl", {write, done}, 2'b01);
    check("cmp_flags", {flag_z, flag_c}, 2'b01);
    step();
    check("cmp_held_flags", {flag_z, flag_c}, 2'b01);
    check("cmp_reg3", regs[3], 8'hFE);

    // MUL r4 = 0x13 * 0x11 = 0x0143
    regs[1] = 8'h13; regs[2] = 8'h11;
    issue(mk(4'd10, 5'd4, 5'd1, 5'd2));
    for (int c = 1; c <= 10; c++) begin
      check($sformatf("mul_c%0d_ready", c), instr_ready, 0);
      check($sformatf("mul_c%0d_write", c), write, (c == 10));
      if (c == 10) begin
        check("mul_wd", wd, 4);
        check("mul_wdata", wdata, 8'h43);
        check("mul_flags", {flag_z, flag_c}, 2'b01);
        check("mul_done", done, 1);
      end
      step();
    end
    check("mul_c11_ready", instr_ready, 1);
    check("mul_reg4", regs[4], 8'h43);

    // Reset in cycle 5 of a MUL
    issue(mk(4'd10, 5'd4, 5'd1, 5'd2));
    nwrites = 0;
    for (int c = 1; c < 5; c++) begin
      if (write) nwrites++;
      step();
    end
    rst_n = 1'b0;
    #1;
    check("rstmul_busy", busy, 0);
    check("rstmul_ready", instr_ready, 1);
    check("rstmul_flags", {flag_z, flag_c}, 0);
    for (int c = 0; c < 8; c++) begin
      if (write || done) nwrites++;
      step();
    end
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (write || done) nwrites++;
      step();
    end
    check("rstmul_nowrite", nwrites, 0);
    check("rstmul_idle", instr_ready, 1);

    // Stream of three ADDs with instr_valid held high and noise while busy
    regs[1] = 8'h01; regs[2] = 8'h02;
    exp_wd[0] = 8'h03; exp_wd[1] = 8'h04; exp_wd[2] = 8'h07;
    nwrites = 0;
    instr_valid = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      case (c)
        0:       instr = mk(4'd1, 5'd8, 5'd1, 5'd2);
        4:       instr = mk(4'd1, 5'd9, 5'd8, 5'd1);
        8:       instr = mk(4'd1, 5'd10, 5'd9, 5'd8);
        default: instr = mk(4'd2, 5'd11, 5'(c), 5'd3);
      endcase
      if (c >= 9) instr_valid = 1'b0;
      check($sformatf("strm_c%0d_ready", c), instr_ready, (c % 4 == 0));
      check($sformatf("strm_c%0d_write", c), write, (c % 4 == 3));
      if (write) begin
        nwrites++;
        if (c % 4 == 3) begin
          check($sformatf("strm_c%0d_wd", c), wd, 5'(8 + c / 4));
          check($sformatf("strm_c%0d_wdata", c), wdata, exp_wd[c / 4]);
        end
      end
      step();
    end
    check("strm_nwrites", nwrites, 3);
    check("strm_reg10", regs[10], 8'h07);
    check("strm_reg11", regs[11], 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
